// File: rtl/seq_restoring_div.sv
// Radix-2 restoring divider: {2*DW dividend} / {DW divisor} -> DW quotient + DW remainder (macro SIGNED_DIV_EN selects two's-complement operands).
// Latency: DW cycles from the accepting edge to done; divide-by-zero and overflow finish in the cycle right after the accepting edge.
// Backpressure: start is accepted only while busy=0 (IDLE or the done cycle); requests during busy are dropped, results held until next accept.
module seq_restoring_div #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            err_div0,
    output logic            err_ovf
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q;
    logic            busy_q;
    logic            done_q;
    logic [DW-1:0]   quotient_q;
    logic [DW-1:0]   remainder_q;
    logic            err_div0_q;
    logic            err_ovf_q;
    // Partial remainder is always below the divisor, so its carry bit is
    // implicit and only DW bits are stored.
    logic [DW-1:0]   r_q;
    logic [DW-1:0]   q_q;
    logic [DW-1:0]   dv_q;
    logic [CW-1:0]   cnt_q;
`ifdef SIGNED_DIV_EN
    logic            neg_q_q;
    logic            neg_r_q;
`endif

    logic [2*DW-1:0] dd_mag_d;
    logic [DW-1:0]   dv_mag_d;
    logic [DW:0]     shift_d;
    logic            no_borrow_d;
    logic [DW-1:0]   r_step_d;
    logic [DW-1:0]   q_step_d;
    logic [DW-1:0]   q_fin_d;
    logic [DW-1:0]   r_fin_d;
    logic            ovf_fin_d;

    // Operand magnitudes, one restoring step, and final sign correction.
    always_comb begin
        dd_mag_d = dividend;
        dv_mag_d = divisor;
`ifdef SIGNED_DIV_EN
        if (dividend[2*DW-1]) dd_mag_d = -dividend;
        if (divisor[DW-1])    dv_mag_d = -divisor;
`endif
        shift_d     = {r_q, q_q[DW-1]};
        no_borrow_d = (shift_d >= {1'b0, dv_q});
        // True difference is below the divisor, so DW-bit wraparound is exact.
        r_step_d    = no_borrow_d ? (shift_d[DW-1:0] - dv_q) : shift_d[DW-1:0];
        q_step_d    = {q_q[DW-2:0], no_borrow_d};
        q_fin_d     = q_step_d;
        r_fin_d     = r_step_d;
        ovf_fin_d   = 1'b0;
`ifdef SIGNED_DIV_EN
        // Magnitude 2^(DW-1) cannot be represented as a positive result and
        // is treated as overflow even when the true result would be negative.
        ovf_fin_d = q_step_d[DW-1];
        if (neg_q_q) q_fin_d = -q_step_d;
        if (neg_r_q) r_fin_d = -r_step_d;
`endif
    end

    // Control FSM with registered outputs and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            err_div0_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
            r_q         <= '0;
            q_q         <= '0;
            dv_q        <= '0;
            cnt_q       <= '0;
`ifdef SIGNED_DIV_EN
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                RUN: begin
                    r_q   <= r_step_d;
                    q_q   <= q_step_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DW - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (ovf_fin_d) begin
                            err_ovf_q   <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= '0;
                        end else begin
                            quotient_q  <= q_fin_d;
                            remainder_q <= r_fin_d;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; done is a single-cycle pulse.
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    if (start) begin
                        err_div0_q <= 1'b0;
                        err_ovf_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
                        neg_q_q <= dividend[2*DW-1] ^ divisor[DW-1];
                        neg_r_q <= dividend[2*DW-1];
`endif
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            err_div0_q  <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend[DW-1:0];
                        end else if (dd_mag_d[2*DW-1:DW] >= dv_mag_d) begin
                            // Upper half at or above divisor: quotient needs more than DW bits.
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            err_ovf_q   <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= '0;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            r_q     <= dd_mag_d[2*DW-1:DW];
                            q_q     <= dd_mag_d[DW-1:0];
                            dv_q    <= dv_mag_d;
                            cnt_q   <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign err_div0  = err_div0_q;
    assign err_ovf   = err_ovf_q;

endmodule
